tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
- Sequential stimulus-and-capture stage wrapped around a 4-input combinational lab function (inputs A,B,C,D; output F).
- On start, drives the DUT inputs through all 16 combinations in binary order (A = MSB, D = LSB) and holds each vector for a programmable dwell.
- Samples F once per vector and assembles the 16-bit truth table, then compares it against an expected table and reports pass/fail plus a mismatch count.
- Replaces hand-written exhaustive stimulus with a synthesizable sweeper usable on the lab board.

Parameters:
- DWELL, 4, cycles each vector is held before F is sampled; legal range 1..255.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin sweep; honoured only in IDLE.
- abort, input, 1, cancel sweep in progress; synchronous.
- exp_tt, input, 16, expected truth table; bit i = expected F for vector i; latched at start.
- f, input, 1, DUT output F.
- a, output, 1, DUT input A (vector bit 3).
- b, output, 1, DUT input B (vector bit 2).
- c, output, 1, DUT input C (vector bit 1).
- d, output, 1, DUT input D (vector bit 0).
- busy, output, 1, high in DRIVE and SAMPLE.
- done, output, 1, one-cycle pulse when a sweep completes.
- tt, output, 16, captured truth table; bit i = F sampled for vector i.
- mismatch_cnt, output, 5, number of bits where tt differs from latched exp_tt (0..16).
- pass, output, 1, 1 when the last completed sweep had mismatch_cnt = 0; held until the next start.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; a,b,c,d,busy,done,pass = 0; tt, mismatch_cnt, vector index idx, dwell counter = 0; latched exp = 0.
- States: IDLE, DRIVE, SAMPLE, DONE. Registered outputs only; {a,b,c,d} = idx at all times outside IDLE/DONE, and 0 in IDLE.
- IDLE:
  - start = 1 → DRIVE next cycle; same edge loads idx = 0, dwell = 0, latches exp_tt, and clears tt, mismatch_cnt and pass.
- DRIVE:
  - dwell increments each cycle.
  - When dwell = DWELL-1 → SAMPLE. Each vector is therefore stable on a..d for DWELL cycles before sampling.
- SAMPLE (one cycle):
  - tt[idx] <= f.
  - If f != exp[idx], mismatch_cnt increments; the 5-bit count never wraps, max 16.
  - If idx = 15 → DONE; else idx <= idx+1, dwell <= 0 → DRIVE.
- Cycle count: DWELL+1 cycles per vector; the first DRIVE cycle to the DONE state spans exactly 16*(DWELL+1) cycles.
- DONE (one cycle):
  - done = 1; pass = (mismatch_cnt == 0); a..d return to 0; → IDLE.
  - done is low in every other state.
- start while busy or in DONE: ignored, with no restart and no corruption.
- abort (DRIVE or SAMPLE):
  - Next state is IDLE, with no done pulse; pass forced 0; a..d = 0.
  - tt and mismatch_cnt keep their partial values.
  - abort overrides a SAMPLE in the same cycle, so that sample is not captured.
  - abort in IDLE/DONE has no effect; abort and start together in IDLE → stays IDLE.
- Changing exp_tt mid-sweep has no effect, because the value was latched at start.
- Async reset mid-sweep: all outputs clear immediately, without waiting for a clock edge.

Test Plan:
1. Assert rst_n low mid-cycle, then hold it low for 3 cycles → all outputs 0 immediately. Release, idle 5 cycles → busy = 0, done never pulses.
2. DWELL = 4, bench DUT F = A^B^C^D, exp_tt = 16'h6996, pulse start →
   - {a,b,c,d} steps 0..15, each value held 5 cycles;
   - done pulses 80 cycles after the first DRIVE cycle;
   - tt = 16'h6996, mismatch_cnt = 0, pass = 1.
3. Same DUT with exp_tt = 16'h6997 → tt = 16'h6996, mismatch_cnt = 1, pass = 0. Then F tied 0 with exp_tt = 16'hFFFF → mismatch_cnt = 16 (no wrap), pass = 0.
4. Pulse abort while idx = 7 → IDLE next cycle, busy = 0, no done, pass = 0, tt bits [15:7] = 0. Then a new start completes normally with pass = 1.
5. Pulse start again at idx = 3 and toggle exp_tt mid-sweep → sweep unaffected; single done after the 80-cycle sweep; result matches the originally latched exp_tt.
6. Assert rst_n low at idx = 10 → a..d, busy and tt clear asynchronously. After release, the next start sweeps from vector 0.

Source files
------------

// File: rtl/tt_sweep_checker_if.sv
// Stimulus/capture bundle between the sweep checker and the lab function
// it exercises. The checker is the slave; the controlling side is the master.
interface tt_sweep_checker_if;
   logic        start;
   logic        abort;
   logic [15:0] exp_tt;
   logic        f;
   logic        a;
   logic        b;
   logic        c;
   logic        d;
   logic        busy;
   logic        done;
   logic [15:0] tt;
   logic [4:0]  mismatch_cnt;
   logic        pass;

   modport slave (
      input  start, abort, exp_tt, f,
      output a, b, c, d, busy, done, tt, mismatch_cnt, pass
   );

   modport master (
      output start, abort, exp_tt, f,
      input  a, b, c, d, busy, done, tt, mismatch_cnt, pass
   );
endinterface

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper for a 4-input combinational lab function.
// Steps {A,B,C,D} through 0..15, holds each vector for DWELL cycles, samples
// F once per vector, and compares the captured table with the one latched
// at start. Every output is driven straight from a register.
module tt_sweep_checker #(
   parameter int unsigned DWELL = 4   // legal range 1..255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   tt_sweep_checker_if.slave       sw_if
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  dwell_q, dwell_d;
   logic [15:0] exp_q, exp_d;
   logic [15:0] tt_q, tt_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        pass_q, pass_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [3:0]  abcd_q, abcd_d;

   // Mismatch counter saturates at 16 so it can never wrap to zero.
   function automatic logic [4:0] sat_inc(input logic [4:0] v);
      if (v >= 5'd16) begin
         sat_inc = 5'd16;
      end else begin
         sat_inc = v + 5'd1;
      end
   endfunction

   // Next-state, capture and registered-output decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dwell_d = dwell_q;
      exp_d   = exp_q;
      tt_d    = tt_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;

      case (state_q)
         S_IDLE: begin
            // abort wins over start so a simultaneous pair stays idle
            if (sw_if.start && !sw_if.abort) begin
               state_d = S_DRIVE;
               idx_d   = 4'd0;
               dwell_d = 8'd0;
               exp_d   = sw_if.exp_tt;
               tt_d    = 16'd0;
               cnt_d   = 5'd0;
               pass_d  = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DRIVE: begin
            if (sw_if.abort) begin
               state_d = S_IDLE;
               pass_d  = 1'b0;
            end else if (dwell_q == DWELL_LAST) begin
               state_d = S_SAMPLE;
               dwell_d = dwell_q + 8'd1;
            end else begin
               dwell_d = dwell_q + 8'd1;
            end
         end
         S_SAMPLE: begin
            // an abort here drops the sample entirely
            if (sw_if.abort) begin
               state_d = S_IDLE;
               pass_d  = 1'b0;
            end else begin
               tt_d[idx_q] = sw_if.f;
               if (sw_if.f != exp_q[idx_q]) begin
                  cnt_d = sat_inc(cnt_q);
               end else begin
                  cnt_d = cnt_q;
               end
               if (idx_q == 4'd15) begin
                  state_d = S_DONE;
                  // verdict appears together with the done pulse
                  pass_d  = (cnt_d == 5'd0);
               end else begin
                  state_d = S_DRIVE;
                  idx_d   = idx_q + 4'd1;
                  dwell_d = 8'd0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
      done_d = (state_d == S_DONE);
      abcd_d = busy_d ? idx_d : 4'd0;
   end

   // State, datapath and output registers; async reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         dwell_q <= 8'd0;
         exp_q   <= 16'd0;
         tt_q    <= 16'd0;
         cnt_q   <= 5'd0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abcd_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dwell_q <= dwell_d;
         exp_q   <= exp_d;
         tt_q    <= tt_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abcd_q  <= abcd_d;
      end
   end

   assign sw_if.a            = abcd_q[3];
   assign sw_if.b            = abcd_q[2];
   assign sw_if.c            = abcd_q[1];
   assign sw_if.d            = abcd_q[0];
   assign sw_if.busy         = busy_q;
   assign sw_if.done         = done_q;
   assign sw_if.tt           = tt_q;
   assign sw_if.mismatch_cnt = cnt_q;
   assign sw_if.pass         = pass_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench for tt_sweep_checker with DWELL = 4.
// The lab function is modelled as 4-input parity (truth table 16'h6996)
// or as a constant 0.
module tb_tt_sweep_checker;

   typedef struct {
      logic [15:0] exp_tt;
      logic        f_zero;
      logic [15:0] tt;
      logic [4:0]  cnt;
      logic        pass;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic f_zero;
   int   n_pass  = 0;
   int   n_total = 0;

   tt_sweep_checker_if sw();

   logic [3:0] abcd_s;
   assign abcd_s = {sw.a, sw.b, sw.c, sw.d};
   assign sw.f   = f_zero ? 1'b0 : ^abcd_s;

   tt_sweep_checker #(.DWELL(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw_if (sw)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full sweep: checks vector trace, 80-cycle latency and a single done.
   // poke >= 0 re-pulses start and flips exp_tt when vector 'poke' appears.
   task automatic sweep(input logic [15:0] e, input logic fz, input int poke);
      int lat;
      int trace_err;
      int extra_done;
      sw.exp_tt = e;
      f_zero    = fz;
      sw.start  = 1'b1;
      tick();
      sw.start  = 1'b0;
      lat       = -1;
      trace_err = 0;
      for (int k = 0; k < 200; k++) begin
         if (sw.done === 1'b1) begin
            lat = k;
            break;
         end
         if (k < 80 && (abcd_s !== 4'(k / 5) || sw.busy !== 1'b1)) trace_err++;
         if (poke >= 0 && k == poke * 5) begin
            sw.start  = 1'b1;
            sw.exp_tt = ~e;
         end else begin
            sw.start  = 1'b0;
         end
         tick();
      end
      sw.start = 1'b0;
      chk("done_latency", 32'(lat), 32'd80);
      chk("vector_trace", 32'(trace_err), 32'd0);
      chk("abcd_busy_in_done", {27'd0, abcd_s, sw.busy}, 32'd0);
      extra_done = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (sw.done !== 1'b0) extra_done++;
      end
      chk("single_done", 32'(extra_done), 32'd0);
   endtask

   task automatic wait_vec(input logic [3:0] v);
      int found;
      found = 0;
      for (int k = 0; k < 200; k++) begin
         if (sw.busy === 1'b1 && abcd_s === v) begin
            found = 1;
            break;
         end
         tick();
      end
      chk("wait_vec", 32'(found), 32'd1);
   endtask

   initial begin
      vec_t tbl[6];
      int   bad;

      tbl[0] = '{16'h6996, 1'b0, 16'h6996, 5'd0,  1'b1};
      tbl[1] = '{16'h6997, 1'b0, 16'h6996, 5'd1,  1'b0};
      tbl[2] = '{16'hFFFF, 1'b1, 16'h0000, 5'd16, 1'b0};
      tbl[3] = '{16'h0001, 1'b0, 16'h6996, 5'd9,  1'b0};
      tbl[4] = '{16'h9669, 1'b0, 16'h6996, 5'd16, 1'b0};
      tbl[5] = '{16'h0000, 1'b1, 16'h0000, 5'd0,  1'b1};

      // 1: asynchronous reset mid-cycle, then idle
      rst_n     = 1'b1;
      sw.start  = 1'b0;
      sw.abort  = 1'b0;
      sw.exp_tt = 16'h0000;
      f_zero    = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("reset_outputs", {4'd0, abcd_s, sw.busy, sw.done, sw.pass, sw.tt, sw.mismatch_cnt}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (sw.busy !== 1'b0 || sw.done !== 1'b0) bad++;
      end
      chk("idle_quiet", 32'(bad), 32'd0);

      // 2/3: table of complete sweeps
      for (int i = 0; i < 6; i++) begin
         sweep(tbl[i].exp_tt, tbl[i].f_zero, -1);
         chk("tt",           32'(sw.tt),           32'(tbl[i].tt));
         chk("mismatch_cnt", 32'(sw.mismatch_cnt), 32'(tbl[i].cnt));
         chk("pass",         32'(sw.pass),         32'(tbl[i].pass));
      end

      // abort together with start in IDLE keeps the block idle
      sw.start = 1'b1;
      sw.abort = 1'b1;
      tick();
      sw.start = 1'b0;
      sw.abort = 1'b0;
      chk("start_abort_idle", {31'd0, sw.busy}, 32'd0);
      chk("start_abort_pass_kept", {31'd0, sw.pass}, 32'd1);

      // 4: abort at vector 7
      sw.exp_tt = 16'h6996;
      f_zero    = 1'b0;
      sw.start  = 1'b1;
      tick();
      sw.start  = 1'b0;
      wait_vec(4'd7);
      sw.abort = 1'b1;
      tick();
      sw.abort = 1'b0;
      chk("abort_busy_abcd", {27'd0, abcd_s, sw.busy}, 32'd0);
      chk("abort_pass", {31'd0, sw.pass}, 32'd0);
      chk("abort_tt_partial", 32'(sw.tt), 32'h0016);
      chk("abort_cnt", 32'(sw.mismatch_cnt), 32'd0);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (sw.done !== 1'b0 || sw.busy !== 1'b0) bad++;
         tick();
      end
      chk("abort_no_done", 32'(bad), 32'd0);
      sweep(16'h6996, 1'b0, -1);
      chk("after_abort_pass", {31'd0, sw.pass}, 32'd1);

      // 5: start re-pulsed and exp_tt flipped at vector 3
      sweep(16'h6996, 1'b0, 3);
      chk("poke_tt", 32'(sw.tt), 32'h6996);
      chk("poke_cnt", 32'(sw.mismatch_cnt), 32'd0);
      chk("poke_pass", {31'd0, sw.pass}, 32'd1);

      // 6: asynchronous reset at vector 10
      sw.exp_tt = 16'h6996;
      sw.start  = 1'b1;
      tick();
      sw.start  = 1'b0;
      wait_vec(4'd10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_abcd_busy", {27'd0, abcd_s, sw.busy}, 32'd0);
      chk("midreset_tt", 32'(sw.tt), 32'd0);
      chk("midreset_cnt", 32'(sw.mismatch_cnt), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      sweep(16'h6996, 1'b0, -1);
      chk("post_reset_tt", 32'(sw.tt), 32'h6996);
      chk("post_reset_pass", {31'd0, sw.pass}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
